// File: rtl/minesweeper_pkg.sv
// Shared types and board geometry defaults for the minesweeper board/video datapath.
package minesweeper_pkg;

  localparam int unsigned BOARD_ADDR_W = 8;
  localparam int unsigned CELL_W       = 8;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CTL,
    OWN_VID
  } owner_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; flags when it sits at MAX.
module sat_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != W'(MAX))) begin
      count <= count + W'(1);
    end
  end

  assign at_max = (count == W'(MAX));

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port board RAM arbiter: renderer-priority reads, bounded controller wait,
// and a time-limited controller lock for atomic read-modify-write.
module board_mem_arbiter
  import minesweeper_pkg::*;
#(
  parameter int unsigned ADDR_W         = BOARD_ADDR_W,
  parameter int unsigned DATA_W         = CELL_W,
  parameter int unsigned CTL_STARVE_MAX = 4,
  parameter int unsigned LOCK_MAX       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctl_req,
  input  logic              ctl_we,
  input  logic              ctl_lock,
  input  logic [ADDR_W-1:0] ctl_addr,
  input  logic [DATA_W-1:0] ctl_wdata,
  output logic              ctl_gnt,
  output logic              ctl_rvalid,
  output logic [DATA_W-1:0] ctl_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lock_err
);

  arb_state_t state, state_next;
  owner_t     tag, tag_next;
  logic       ctl_win, vid_win;
  logic       wait_at_max, lock_at_max;
  logic       locked, force_release;

  assign locked        = (state == ARB_LOCKED);
  assign force_release = locked & lock_at_max;

  sat_counter #(.MAX(CTL_STARVE_MAX)) u_ctl_wait (
    .clk    (clk),
    .reset  (reset),
    .inc    (ctl_req & ~ctl_win),
    .clr    (~ctl_req | ctl_win),
    .at_max (wait_at_max)
  );

  // Cleared whenever not locked, and on a same-cycle release/relock, so every entry starts at 0.
  sat_counter #(.MAX(LOCK_MAX)) u_lock_cnt (
    .clk    (clk),
    .reset  (reset),
    .inc    (locked),
    .clr    (~locked | force_release),
    .at_max (lock_at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      tag      <= OWN_NONE;
      lock_err <= 1'b0;
    end else begin
      state <= state_next;
      tag   <= tag_next;
      if (force_release) lock_err <= 1'b1;
    end
  end

  // Grant selection and next state; a forced release falls through to IDLE arbitration.
  always_comb begin
    ctl_win    = 1'b0;
    vid_win    = 1'b0;
    state_next = state;
    tag_next   = OWN_NONE;
    if (reset) begin
      state_next = ARB_IDLE;
    end else if (!locked || force_release) begin
      ctl_win    = ctl_req & (~vid_req | wait_at_max);
      vid_win    = vid_req & ~ctl_win;
      state_next = (ctl_win && ctl_lock) ? ARB_LOCKED : ARB_IDLE;
    end else begin
      ctl_win = ctl_req;
      if (!ctl_lock) state_next = ARB_IDLE;
    end
    if (ctl_win && !ctl_we) tag_next = OWN_CTL;
    else if (vid_win)       tag_next = OWN_VID;
  end

  assign ctl_gnt   = ctl_win;
  assign vid_gnt   = vid_win;
  assign mem_en    = ctl_win | vid_win;
  assign mem_we    = ctl_win & ctl_we;
  assign mem_addr  = ctl_win ? ctl_addr  : (vid_win ? vid_addr : '0);
  assign mem_wdata = ctl_win ? ctl_wdata : '0;

  // Reset masks the return path so a read granted just before reset never completes.
  assign ctl_rvalid = (tag == OWN_CTL) & ~reset;
  assign vid_rvalid = (tag == OWN_VID) & ~reset;
  assign ctl_rdata  = reset ? '0 : mem_rdata;
  assign vid_rdata  = reset ? '0 : mem_rdata;

endmodule
